// File: rtl/mdu_hi_lo_if.sv
// Decode-side connection to the HI/LO multiply/divide unit.
// Handshake: decode drives start with op/a/b; the unit accepts only in IDLE. After accept it ignores
// start until it returns to IDLE. ready pulses once with hi/lo/div_zero valid, and stall_out holds
// fetch from accept until ready.
interface mdu_hi_lo_if #(parameter int WIDTH = 16);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             ready;
  logic             stall_out;
  logic             div_zero;
  logic [2:0]       state_dbg;

  modport master (
    output start, op, a, b,
    input  hi, lo, busy, ready, stall_out, div_zero, state_dbg
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, ready, stall_out, div_zero, state_dbg
  );
endinterface

// File: rtl/mdu_hi_lo.sv
// Iterative mult/multu/div/divu unit producing HI/LO for the 16-bit MIPS core.
// Magnitudes are iterated one bit per cycle; signs are applied in a single FIX step.
module mdu_hi_lo #(
  parameter int WIDTH = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  mdu_hi_lo_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               state, state_nx;
  logic                 is_div_q, neg_res, neg_rem, dz_q;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 div_zero_q;

  logic                 accept, is_div, a_neg, b_neg, b_zero, last_iter;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum, rem_sh;
  logic [WIDTH+1:0]     trial;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign accept    = (state == S_IDLE) && bus.start;
  assign is_div    = bus.op[1];
  assign a_neg     = ~bus.op[0] & bus.a[WIDTH-1];
  assign b_neg     = ~bus.op[0] & bus.b[WIDTH-1];
  assign b_zero    = (bus.b == '0);
  assign a_abs     = a_neg ? ('0 - bus.a) : bus.a;
  assign b_abs     = b_neg ? ('0 - bus.b) : bus.b;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // Multiply: multiplier sits in acc low half and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  // Divide: remainder:quotient shifted left; one extra bit keeps the shifted remainder exact.
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign trial    = {1'b0, rem_sh} - {2'b00, opnd};
  assign prod_fix = neg_res ? ('0 - acc) : acc;
  assign quo_fix  = neg_res ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = (is_div && b_zero) ? S_FIX : (is_div ? S_DIV : S_MUL);
      S_MUL:  if (last_iter) state_nx = S_FIX;
      S_DIV:  if (last_iter) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    bus.ready     = (state == S_DONE);
    bus.stall_out = bus.busy || (bus.start && (state == S_IDLE));
    bus.state_dbg = state;
    bus.hi        = hi_q;
    bus.lo        = lo_q;
    bus.div_zero  = div_zero_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      is_div_q   <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      dz_q       <= 1'b0;
      acc        <= '0;
      opnd       <= '0;
      cnt        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          is_div_q   <= is_div;
          neg_res    <= a_neg ^ b_neg;
          neg_rem    <= a_neg;
          dz_q       <= is_div && b_zero;
          cnt        <= '0;
          div_zero_q <= 1'b0;
          if (is_div && b_zero) begin
            acc  <= {bus.a, {WIDTH{1'b0}}};
            opnd <= '0;
          end else if (is_div) begin
            acc  <= {{WIDTH{1'b0}}, a_abs};
            opnd <= b_abs;
          end else begin
            acc  <= {{WIDTH{1'b0}}, b_abs};
            opnd <= a_abs;
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
        end
        S_DIV: begin
          if (!trial[WIDTH+1]) acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else                 acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          cnt <= cnt + CW'(1);
        end
        S_FIX: begin
          // Divide-by-zero passes the raw dividend to HI and saturates LO.
          if (dz_q) begin
            hi_q       <= acc[2*WIDTH-1:WIDTH];
            lo_q       <= '1;
            div_zero_q <= 1'b1;
          end else if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_hi_lo.sv
// Directed plus random checks of mdu_hi_lo: results via an expected queue, cycle-accurate timing,
// ignored starts and asynchronous abort.
module tb_mdu_hi_lo;
  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] last_res;

  mdu_hi_lo_if #(.WIDTH(16)) bus ();

  mdu_hi_lo #(.WIDTH(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference results as {div_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [32:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    int sx, sy, q, r;
    logic [31:0] p;
    sx = int'($signed(x));
    sy = int'($signed(y));
    case (o)
      2'b00: begin p = 32'(sx * sy); return {1'b0, p}; end
      2'b01: begin p = {16'h0, x} * {16'h0, y}; return {1'b0, p}; end
      default: begin
        if (y == 16'h0) return {1'b1, x, 16'hFFFF};
        if (o == 2'b10) begin q = sx / sy; r = sx % sy; end
        else begin q = int'(x) / int'(y); r = int'(x) % int'(y); end
        return {1'b0, r[15:0], q[15:0]};
      end
    endcase
  endfunction

  // Called just after a negative edge; issues one op and follows it to ready.
  task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [32:0] expv, input int exp_lat, input bit poke_done);
    int cyc;
    bit seen;
    logic [32:0] got, want;
    exp_q.push_back(expv);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    #1;
    chk("stall_accept", 64'(bus.stall_out), 64'd1);
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.op = 2'($urandom_range(0, 3));
    bus.a = 16'($urandom_range(0, 65535));
    bus.b = 16'($urandom_range(0, 65535));
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc <= 40) begin
      @(negedge clock);
      if (cyc == 1) begin
        chk("div_zero_clr", 64'(bus.div_zero), 64'd0);
        chk("hold_hilo", 64'({bus.hi, bus.lo}), 64'(last_res[31:0]));
      end
      if (bus.ready) seen = 1'b1;
      else begin
        chk("busy_iter", 64'(bus.busy), 64'd1);
        chk("stall_iter", 64'(bus.stall_out), 64'd1);
        cyc++;
      end
    end
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("stall_done", 64'(bus.stall_out), 64'd0);
    chk("busy_done", 64'(bus.busy), 64'd0);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      want = exp_q.pop_front();
      got = {bus.div_zero, bus.hi, bus.lo};
      chk("result", 64'(got), 64'(want));
      last_res = want;
    end
    if (poke_done) begin
      bus.start = 1'b1;
      bus.op = 2'b01;
      bus.b = 16'h0003;
      @(posedge clock); #1;
      bus.start = 1'b0;
      @(negedge clock);
      chk("start_in_done_ignored", 64'(bus.busy), 64'd0);
      chk("state_idle_after_poke", 64'(bus.state_dbg), 64'd0);
    end else begin
      @(negedge clock);
      chk("ready_pulse", 64'(bus.ready), 64'd0);
      chk("state_idle", 64'(bus.state_dbg), 64'd0);
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [15:0] ra, rb;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = 16'h0; bus.b = 16'h0;
    last_res = 33'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_hi", 64'(bus.hi), 64'h0);
    chk("rst_lo", 64'(bus.lo), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    do_op(2'b00, 16'hFFFD, 16'h0007, {1'b0, 16'hFFFF, 16'hFFEB}, 18, 1'b0);
    do_op(2'b01, 16'hFFFF, 16'hFFFF, {1'b0, 16'hFFFE, 16'h0001}, 18, 1'b0);
    do_op(2'b00, 16'hFFFF, 16'hFFFF, {1'b0, 16'h0000, 16'h0001}, 18, 1'b0);
    do_op(2'b10, 16'hFFF9, 16'h0002, {1'b0, 16'hFFFF, 16'hFFFD}, 18, 1'b1);
    do_op(2'b11, 16'd100,  16'd7,    {1'b0, 16'd2,    16'd14},   18, 1'b0);
    do_op(2'b10, 16'h0005, 16'h0000, {1'b1, 16'h0005, 16'hFFFF}, 2,  1'b0);

    // Abort a multiply with reset partway through; an extra start mid-run must be ignored.
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'h1234; bus.b = 16'h0010;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 16'h0077; bus.b = 16'h0005;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(negedge clock);
    chk("mid_start_ignored", 64'(bus.state_dbg), 64'd1);
    @(posedge clock);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk("abort_hi", 64'(bus.hi), 64'h0);
    chk("abort_lo", 64'(bus.lo), 64'h0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_div_zero", 64'(bus.div_zero), 64'd0);
    chk("abort_stall", 64'(bus.stall_out), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    last_res = 33'h0;
    @(negedge clock);

    do_op(2'b11, 16'h8000, 16'h0003, {1'b0, 16'h0002, 16'h2AAA}, 18, 1'b0);
    do_op(2'b10, 16'h8000, 16'hFFFF, {1'b0, 16'h0000, 16'h8000}, 18, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom_range(0, 65535));
      rb = (i == 5) ? 16'h0000 : 16'($urandom_range(0, 65535));
      do_op(ro, ra, rb, model(ro, ra, rb), (ro[1] && rb == 16'h0) ? 2 : 18, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
